// File: rtl/a2d_chan_seq.sv
// A2D channel sequencer: walks a configurable ADC128S channel list through the SPI monarch,
// optionally IIR-filters each result and maintains a hysteretic low-battery flag.
module a2d_chan_seq #(
  parameter int unsigned NUM_CH     = 4,
  parameter logic [23:0] CH_MAP     = 24'o0000_4530,
  parameter int unsigned FILT_SHIFT = 0,
  parameter int unsigned BATT_SLOT  = 2,
  parameter logic [11:0] BATT_THRES = 12'h800,
  parameter logic [11:0] BATT_HYST  = 12'h040
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   nxt,
  input  logic                   cont,
  output logic                   wrt,
  output logic [15:0]            cmd,
  input  logic                   done,
  input  logic [15:0]            rd_data,
  output logic [12*NUM_CH-1:0]   res_vec,
  output logic                   res_vld,
  output logic [2:0]             slot_idx,
  output logic                   round_done,
  output logic                   batt_low,
  output logic                   busy
);

  localparam int unsigned RES_W = 12;
  localparam int unsigned VEC_W = RES_W * NUM_CH;
  localparam logic [2:0]  LAST_SLOT = 3'(NUM_CH - 1);
  localparam logic [2:0]  BATT_IDX  = 3'(BATT_SLOT);
  localparam bit          FILT_EN   = (FILT_SHIFT != 0);
  localparam logic [12:0] REL_SUM   = 13'(BATT_THRES) + 13'(BATT_HYST);
  localparam logic [11:0] BATT_REL  = REL_SUM[12] ? 12'hFFF : REL_SUM[11:0];

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WAIT1, S_GAP, S_RD, S_WAIT2, S_UPDATE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         slot_q, slot_d;
  logic               pending_q, pending_d;
  logic               wrt_q, wrt_d;
  logic [15:0]        cmd_q, cmd_d;
  logic [VEC_W-1:0]   res_vec_q, res_vec_d;
  logic               res_vld_q, res_vld_d;
  logic [2:0]         slot_idx_q, slot_idx_d;
  logic               round_done_q, round_done_d;
  logic               batt_low_q, batt_low_d;
  logic               busy_q, busy_d;
  logic [NUM_CH-1:0]  first_q, first_d;

  logic [2:0]         slot_adv, cmd_slot, ch_sel;
  logic [15:0]        slot_cmd;
  logic [11:0]        sample, res_old, new_res;
  logic               first_old;
  logic signed [12:0] delta, delta_sh;
  logic               unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:12];

  // Slot bookkeeping, per-slot lookups and the IIR update for the captured sample
  always_comb begin
    slot_adv  = (slot_q == LAST_SLOT) ? 3'd0 : 3'(slot_q + 3'd1);
    cmd_slot  = (state_q == S_UPDATE) ? slot_adv : slot_q;
    ch_sel    = 3'd0;
    res_old   = 12'h000;
    first_old = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (cmd_slot == 3'(k)) ch_sel = CH_MAP[3*k +: 3];
      if (slot_q == 3'(k)) begin
        res_old   = res_vec_q[RES_W*k +: RES_W];
        first_old = first_q[k];
      end
    end
    slot_cmd = {2'b00, ch_sel, 11'h000};
    sample   = rd_data[11:0];
    delta    = $signed({1'b0, sample}) - $signed({1'b0, res_old});
    delta_sh = delta >>> FILT_SHIFT;
    new_res  = (!FILT_EN || first_old) ? sample : 12'(res_old + delta_sh[11:0]);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    pending_d    = pending_q;
    wrt_d        = 1'b0;
    cmd_d        = cmd_q;
    res_vec_d    = res_vec_q;
    res_vld_d    = 1'b0;
    slot_idx_d   = slot_idx_q;
    round_done_d = 1'b0;
    batt_low_d   = batt_low_q;
    first_d      = first_q;

    if (state_q != S_IDLE && nxt) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (nxt || pending_q || cont) begin
          state_d   = S_CMD;
          pending_d = 1'b0;
          wrt_d     = 1'b1;
          cmd_d     = slot_cmd;
        end
      end
      S_CMD:   state_d = S_WAIT1;
      S_WAIT1: if (done) state_d = S_GAP;
      S_GAP: begin
        state_d = S_RD;
        wrt_d   = 1'b1;
        cmd_d   = slot_cmd;
      end
      S_RD:    state_d = S_WAIT2;
      S_WAIT2: begin
        if (done) begin
          state_d      = S_UPDATE;
          res_vld_d    = 1'b1;
          slot_idx_d   = slot_q;
          round_done_d = (slot_q == LAST_SLOT);
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (slot_q == 3'(k)) begin
              res_vec_d[RES_W*k +: RES_W] = new_res;
              first_d[k]                  = 1'b0;
            end
          end
          if (slot_q == BATT_IDX) begin
            if (new_res < BATT_THRES)      batt_low_d = 1'b1;
            else if (new_res >= BATT_REL)  batt_low_d = 1'b0;
          end
        end
      end
      S_UPDATE: begin
        slot_d = slot_adv;
        // pending is consumed by this hand-off; an nxt seen now queues the next one
        pending_d = nxt;
        if (pending_q || cont) begin
          state_d = S_CMD;
          wrt_d   = 1'b1;
          cmd_d   = slot_cmd;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      slot_q       <= 3'd0;
      pending_q    <= 1'b0;
      wrt_q        <= 1'b0;
      cmd_q        <= 16'h0000;
      res_vec_q    <= '0;
      res_vld_q    <= 1'b0;
      slot_idx_q   <= 3'd0;
      round_done_q <= 1'b0;
      batt_low_q   <= 1'b0;
      busy_q       <= 1'b0;
      first_q      <= '1;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      pending_q    <= pending_d;
      wrt_q        <= wrt_d;
      cmd_q        <= cmd_d;
      res_vec_q    <= res_vec_d;
      res_vld_q    <= res_vld_d;
      slot_idx_q   <= slot_idx_d;
      round_done_q <= round_done_d;
      batt_low_q   <= batt_low_d;
      busy_q       <= busy_d;
      first_q      <= first_d;
    end
  end

  assign wrt        = wrt_q;
  assign cmd        = cmd_q;
  assign res_vec    = res_vec_q;
  assign res_vld    = res_vld_q;
  assign slot_idx   = slot_idx_q;
  assign round_done = round_done_q;
  assign batt_low   = batt_low_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_a2d_chan_seq.sv
// Directed bench for a2d_chan_seq: default 4-slot instance plus a 1-slot FILT_SHIFT=2 instance
// driven from the same SPI handshake.
module tb_a2d_chan_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        cont = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;

  logic        wrt, res_vld, round_done, batt_low, busy;
  logic [15:0] cmd;
  logic [47:0] res_vec;
  logic [2:0]  slot_idx;

  logic        f_wrt, f_res_vld, f_round_done, f_batt_low, f_busy;
  logic [15:0] f_cmd;
  logic [11:0] f_res_vec;
  logic [2:0]  f_slot_idx;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  a2d_chan_seq u_dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .cont(cont), .wrt(wrt), .cmd(cmd),
    .done(done), .rd_data(rd_data), .res_vec(res_vec), .res_vld(res_vld),
    .slot_idx(slot_idx), .round_done(round_done), .batt_low(batt_low), .busy(busy)
  );

  a2d_chan_seq #(.NUM_CH(1), .FILT_SHIFT(2), .BATT_SLOT(0)) u_filt (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .cont(cont), .wrt(f_wrt), .cmd(f_cmd),
    .done(done), .rd_data(rd_data), .res_vec(f_res_vec), .res_vld(f_res_vld),
    .slot_idx(f_slot_idx), .round_done(f_round_done), .batt_low(f_batt_low), .busy(f_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] cmd_of(input logic [2:0] s);
    case (s)
      3'd0:    return 16'h0000;
      3'd1:    return 16'h1800;
      3'd2:    return 16'h2800;
      default: return 16'h2000;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; nxt = 1'b0; cont = 1'b0; done = 1'b0; rd_data = 16'h0000;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Serve one two-transaction conversion; n1 = cycles until the first wrt is seen
  task automatic convert(input logic [11:0] data, input logic [2:0] exp_slot, input logic exp_rd,
                         input bit drop_cont, input bit nxt_burst, output int n1);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(); n++;
      if (wrt) break;
    end
    n1 = n;
    nxt = 1'b0;
    check_eq("wrt1", wrt, 1'b1);
    check_eq("cmd1", cmd, cmd_of(exp_slot));
    step();
    if (drop_cont) cont = 1'b0;
    if (nxt_burst) repeat (3) begin nxt = 1'b1; step(); nxt = 1'b0; step(); end
    done = 1'b1; rd_data = 16'hDEAD;
    step();
    done = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(); n++;
      if (wrt) break;
    end
    check_eq("wrt2", wrt, 1'b1);
    check_eq("cmd2", cmd, cmd_of(exp_slot));
    step();
    done = 1'b1; rd_data = {4'hF, data};
    step();
    done = 1'b0;
    check_eq("res_vld", res_vld, 1'b1);
    check_eq("slot_idx", slot_idx, exp_slot);
    check_eq("round_done", round_done, exp_rd);
  endtask

  task automatic one_nxt(input logic [11:0] data, input logic [2:0] exp_slot, input logic exp_rd);
    int n1;
    nxt = 1'b1;
    convert(data, exp_slot, exp_rd, 1'b0, 1'b0, n1);
    check_eq("start_lat", n1, 1);
    step();
    check_eq("idle_busy", busy, 1'b0);
    check_eq("vld_pulse", res_vld, 1'b0);
  endtask

  logic [11:0] batt_data [16];
  logic        batt_exp  [16];

  initial begin
    int n1;
    do_reset();
    check_eq("rst_wrt", wrt, 1'b0);
    check_eq("rst_cmd", cmd, 16'h0000);
    check_eq("rst_res", res_vec, 48'h0);
    check_eq("rst_vld", res_vld, 1'b0);
    check_eq("rst_rd", round_done, 1'b0);
    check_eq("rst_batt", batt_low, 1'b0);
    check_eq("rst_busy", busy, 1'b0);

    // Single conversion
    one_nxt(12'hABC, 3'd0, 1'b0);
    check_eq("single_res", res_vec, 48'h0000_0000_0ABC);
    check_eq("single_filt_first", f_res_vec, 12'hABC);

    // One full round plus wrap
    do_reset();
    one_nxt(12'h111, 3'd0, 1'b0);
    one_nxt(12'h222, 3'd1, 1'b0);
    one_nxt(12'h333, 3'd2, 1'b0);
    one_nxt(12'h444, 3'd3, 1'b1);
    check_eq("round_res", res_vec, 48'h444_333_222_111);
    check_eq("round_batt", batt_low, 1'b1);
    one_nxt(12'h555, 3'd0, 1'b0);
    check_eq("wrap_res", res_vec, 48'h444_333_222_555);

    // Battery hysteresis: only slot 2 matters
    for (int i = 0; i < 16; i++) batt_data[i] = 12'h900;
    batt_data[2] = 12'h7FF; batt_data[6] = 12'h820; batt_data[10] = 12'h840;
    batt_data[12] = 12'h100; batt_data[14] = 12'h830;
    for (int i = 0; i < 16; i++) batt_exp[i] = (i >= 2 && i < 10);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      one_nxt(batt_data[i], 3'(i % 4), (i % 4) == 3);
      check_eq($sformatf("batt_low[%0d]", i), batt_low, batt_exp[i]);
    end

    // IIR filter on the single-slot instance
    do_reset();
    one_nxt(12'h400, 3'd0, 1'b0);
    check_eq("filt_0", f_res_vec, 12'h400);
    one_nxt(12'h800, 3'd1, 1'b0);
    check_eq("filt_1", f_res_vec, 12'h500);
    one_nxt(12'h000, 3'd2, 1'b0);
    check_eq("filt_2", f_res_vec, 12'h3C0);
    check_eq("filt_rd", f_round_done, 1'b0);
    check_eq("nofilt_res", res_vec[35:0], 36'h000_800_400);

    // Continuous mode, cont dropped during WAIT1 of the 10th conversion
    do_reset();
    cont = 1'b1;
    for (int i = 0; i < 10; i++) begin
      convert(12'(12'h100 * (i + 1)), 3'(i % 4), (i % 4) == 3, i == 9, 1'b0, n1);
      check_eq($sformatf("cont_b2b[%0d]", i), n1, 1);
    end
    step();
    check_eq("cont_idle", busy, 1'b0);
    repeat (3) begin step(); check_eq("cont_quiet", wrt, 1'b0); end

    // Three nxt pulses during one conversion give exactly one more
    do_reset();
    nxt = 1'b1;
    convert(12'h0AA, 3'd0, 1'b0, 1'b0, 1'b1, n1);
    convert(12'h0BB, 3'd1, 1'b0, 1'b0, 1'b0, n1);
    check_eq("pend_b2b", n1, 1);
    step();
    check_eq("pend_idle", busy, 1'b0);
    repeat (4) begin step(); check_eq("pend_quiet", wrt, 1'b0); end

    // Reset asserted during WAIT2 of a slot-2 conversion; late done ignored
    nxt = 1'b1;
    for (int i = 0; i < 20; i++) begin step(); if (wrt) break; end
    nxt = 1'b0;
    check_eq("mid_cmd", cmd, 16'h2800);
    step();
    done = 1'b1; step(); done = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); if (wrt) break; end
    step();
    check_eq("mid_busy_pre", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_cmd", cmd, 16'h0000);
    check_eq("arst_res", res_vec, 48'h0);
    check_eq("arst_wrt", wrt, 1'b0);
    #1 rst_n = 1'b1;
    step();
    done = 1'b1; rd_data = 16'h0123;
    step();
    done = 1'b0;
    check_eq("late_vld", res_vld, 1'b0);
    repeat (3) begin
      step();
      check_eq("late_busy", busy, 1'b0);
      check_eq("late_res", res_vec, 48'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/a2d_chan_seq.md
Name: a2d_chan_seq

Overview:
Parametrised A2D channel sequencer. It replaces the fixed four-channel round-robin and the inline battery-threshold compare at Segway top level. It drives the existing SPI monarch through its wrt/done handshake, converts a configurable list of ADC128S channels, and optionally IIR-filters each result. It publishes all results as one packed vector and produces a hysteretic batt_low flag. It supports both nxt-triggered and free-running continuous modes.

Parameters:
NUM_CH, 4, number of sequenced channels (1..8)
CH_MAP, 24'o0000_4530, packed 3-bit ADC channel IDs; slot k uses CH_MAP[3k+2:3k] (default: slot0=ch0 lft_ld, slot1=ch3 rght_ld, slot2=ch5 batt, slot3=ch4 steer_pot)
FILT_SHIFT, 0, IIR shift; 0 = no filtering, 1..4 = alpha 2^-FILT_SHIFT
BATT_SLOT, 2, slot index monitored for batt_low
BATT_THRES, 12'h800, batt_low assert threshold
BATT_HYST, 12'h040, batt_low release margin

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset (synchronized by rst_synch upstream)
nxt  in  1  start one conversion of the current slot (pulse; from inertial vld)
cont  in  1  1 = free-running; the next slot starts immediately after UPDATE
wrt  out  1  one-cycle request to the SPI monarch
cmd  out  16  SPI word to send
done  in  1  SPI monarch transaction complete (one-cycle pulse)
rd_data  in  16  SPI word received (valid when done)
res_vec  out  12*NUM_CH  result of slot k at res_vec[12k+11:12k]
res_vld  out  1  one-cycle pulse when any slot is updated
slot_idx  out  3  slot updated on the res_vld cycle
round_done  out  1  one-cycle pulse, coincident with res_vld of slot NUM_CH-1
batt_low  out  1  hysteretic low-battery flag
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: FSM=IDLE, slot=0, pending=0, wrt=0, cmd=0, res_vec=0, res_vld=0, round_done=0, batt_low=0, all first-sample flags set.
- States and transitions:
  - IDLE: on (nxt | pending | cont), go to CMD.
  - CMD: assert wrt for 1 cycle with cmd={2'b00,CH_MAP slot,11'h000}; go to WAIT1.
  - WAIT1: on done, go to GAP.
  - GAP: 1 idle cycle, then go to RD.
  - RD: assert wrt for 1 cycle with the same cmd; go to WAIT2.
  - WAIT2: on done, capture rd_data[11:0] as sample; go to UPDATE.
  - UPDATE: write the slot result, pulse res_vld, advance slot; then go to CMD if (pending | cont), else IDLE.
- Latency: from the nxt cycle, wrt asserts 1 cycle later (CMD). res_vld fires 1 cycle after the second done.
- pending:
  - Set by nxt in any non-IDLE state; one level deep, so extra nxt pulses merge.
  - Cleared when leaving IDLE or UPDATE toward CMD.
  - nxt in IDLE starts directly and does not set pending.
- Slot advance: slot = (slot==NUM_CH-1) ? 0 : slot+1. round_done pulses when the old slot==NUM_CH-1. NUM_CH=1 keeps slot at 0 and pulses round_done on every update.
- Filter:
  - FILT_SHIFT=0: result = sample.
  - Otherwise, on the first sample per slot after reset: result = sample, clear the first-sample flag.
  - Thereafter: result = result + ((sample − result) >>> FILT_SHIFT). The difference is 13-bit signed, arithmetic shift; the sum is truncated to 12 bits and never wraps, since |delta>>>s| ≤ |delta|.
- batt_low is evaluated in UPDATE, only when slot==BATT_SLOT, using the new result:
  - Assert if result < BATT_THRES.
  - Release if result ≥ BATT_THRES+BATT_HYST; the sum saturates at 12'hFFF.
  - Otherwise hold.
- cont falling mid-conversion: the current conversion completes, then go to IDLE unless pending.
- Asynchronous reset mid-transaction: return to the reset state immediately; the following SPI done is ignored in IDLE.
- A done pulse in any state other than WAIT1 or WAIT2 is ignored.

Test Plan:
- Reset, then a single nxt with rd_data=16'h0ABC on both dones → wrt twice with cmd=16'h0000, res_vec[11:0]=12'hABC, res_vld with slot_idx=0, then IDLE.
- 4 nxt pulses, per-slot data 12'h111/222/333/444 → cmds 16'h0000, 16'h1800, 16'h2800, 16'h2000; round_done coincides with the 4th res_vld; slot wraps to 0.
- Batt slot fed 12'h7FF → batt_low=1; then 12'h820 → stays 1; then 12'h840 → batt_low=0.
- FILT_SHIFT=2 on slot 0: samples 12'h400 then 12'h800 → results 12'h400 then 12'h500; sample 12'h000 → 12'h3C0.
- cont=1 held for 10 conversions → back-to-back CMD after each UPDATE with no IDLE cycle; drop cont mid-WAIT1 → one more res_vld, then IDLE.
- 3 nxt pulses during one conversion → exactly one extra conversion. Assert rst_n low during WAIT2 → all outputs return to 0 and the late done is ignored.
